// File: rtl/memch_pkg.sv
// Shared constants for the channel-memory scheduler: bank geometry, FSM encodings
// and a small helper that turns a bank index into its mask bit.
package memch_pkg;

    localparam int NUM_BANKS = 3;
    localparam int BANK_W    = 2;
    localparam int ST_W      = 3;

    typedef logic [NUM_BANKS-1:0] mask_t;
    typedef logic [BANK_W-1:0]    bank_t;

    localparam logic [ST_W-1:0] ST_IDLE      = 3'd0;
    localparam logic [ST_W-1:0] ST_LOAD_REQ  = 3'd1;
    localparam logic [ST_W-1:0] ST_LOAD_WAIT = 3'd2;
    localparam logic [ST_W-1:0] ST_COMPUTE   = 3'd3;
    localparam logic [ST_W-1:0] ST_COMP_WAIT = 3'd4;
    localparam logic [ST_W-1:0] ST_DRAIN     = 3'd5;
    localparam logic [ST_W-1:0] ST_CLEAR     = 3'd6;
    localparam logic [ST_W-1:0] ST_FINISH    = 3'd7;

    localparam bank_t LAST_BANK = 2'd2;
    localparam mask_t MASK_NONE = 3'b000;
    localparam mask_t MASK_ALL  = 3'b111;

    function automatic mask_t bank_onehot(input bank_t b);
        mask_t m;
        case (b)
            2'd0:    m = 3'b001;
            2'd1:    m = 3'b010;
            2'd2:    m = 3'b100;
            default: m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/memch_ch_counter.sv
// Channel index counter: clear/increment, with compares against the latched channel
// count for "next load is the last one" and "all channels loaded".
module memch_ch_counter
    import memch_pkg::*;
#(
    parameter int CH_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [CH_W-1:0] limit,
    output logic [CH_W-1:0] count,
    output logic            last,
    output logic            term
);

    logic [CH_W-1:0] cnt_q;
    logic [CH_W-1:0] cnt_d;

    // next count: clear wins over increment
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CH_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // count never passes limit, so the CH_W-wide compares cannot wrap
    assign count = cnt_q;
    assign last  = ((cnt_q + CH_W'(1)) == limit);
    assign term  = (cnt_q == limit);

endmodule

// File: rtl/memch_scheduler.sv
// Group scheduler for the three channel memories: loads up to three channels round-robin,
// fires the conv engine, waits for compute and write-back, clears the banks, repeats.
module memch_scheduler
    import memch_pkg::*;
#(
    parameter int CH_W = 8
) (
    input  logic            MEMCH_SCHEDULER_Clk,
    input  logic            MEMCH_SCHEDULER_Reset,
    input  logic            MEMCH_SCHEDULER_Start,
    input  logic [CH_W-1:0] MEMCH_SCHEDULER_Num_Ch,
    input  logic            MEMCH_SCHEDULER_Abort,
    input  logic            MEMCH_SCHEDULER_Load_Done,
    input  logic            MEMCH_SCHEDULER_Comp_Done,
    input  logic            MEMCH_SCHEDULER_In_Output_Routine,
    output logic            MEMCH_SCHEDULER_Busy,
    output logic            MEMCH_SCHEDULER_Load_Req,
    output logic [CH_W-1:0] MEMCH_SCHEDULER_Load_Ch,
    output logic [1:0]      MEMCH_SCHEDULER_Load_Bank,
    output logic            MEMCH_SCHEDULER_Comp_Start,
    output logic [2:0]      MEMCH_SCHEDULER_Comp_Mask,
    output logic [2:0]      MEMCH_SCHEDULER_Bank_Clr,
    output logic            MEMCH_SCHEDULER_Done
);

    logic [ST_W-1:0] state_q, state_d;
    logic [CH_W-1:0] num_ch_q, num_ch_d;
    bank_t           bank_q, bank_d;
    mask_t           mask_q, mask_d;
    logic            busy_q, busy_d;
    logic            load_req_q, load_req_d;
    logic [CH_W-1:0] load_ch_q, load_ch_d;
    bank_t           load_bank_q, load_bank_d;
    logic            comp_start_q, comp_start_d;
    mask_t           bank_clr_q, bank_clr_d;
    logic            done_q, done_d;

    logic            ch_clr_s;
    logic            ch_en_s;
    logic [CH_W-1:0] ch_s;
    logic            ch_last_s;
    logic            ch_term_s;

    memch_ch_counter #(.CH_W(CH_W)) u_ch_counter (
        .clk   (MEMCH_SCHEDULER_Clk),
        .rst   (MEMCH_SCHEDULER_Reset),
        .clr   (ch_clr_s),
        .en    (ch_en_s),
        .limit (num_ch_q),
        .count (ch_s),
        .last  (ch_last_s),
        .term  (ch_term_s)
    );

    // next-state and next-output decode; abort pre-empts every state but IDLE
    always_comb begin
        state_d      = state_q;
        num_ch_d     = num_ch_q;
        bank_d       = bank_q;
        mask_d       = mask_q;
        load_req_d   = load_req_q;
        load_ch_d    = load_ch_q;
        load_bank_d  = load_bank_q;
        comp_start_d = 1'b0;
        bank_clr_d   = MASK_NONE;
        done_d       = 1'b0;
        ch_clr_s     = 1'b0;
        ch_en_s      = 1'b0;

        if (MEMCH_SCHEDULER_Abort && (state_q != ST_IDLE)) begin
            state_d    = ST_IDLE;
            load_req_d = 1'b0;
            bank_clr_d = MASK_ALL;
            mask_d     = MASK_NONE;
            bank_d     = 2'd0;
            ch_clr_s   = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (MEMCH_SCHEDULER_Start && !MEMCH_SCHEDULER_Abort) begin
                        num_ch_d = MEMCH_SCHEDULER_Num_Ch;
                        bank_d   = 2'd0;
                        mask_d   = MASK_NONE;
                        ch_clr_s = 1'b1;
                        if (MEMCH_SCHEDULER_Num_Ch == '0) begin
                            state_d = ST_FINISH;
                        end else begin
                            state_d = ST_LOAD_REQ;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD_REQ: begin
                    load_req_d  = 1'b1;
                    load_ch_d   = ch_s;
                    load_bank_d = bank_q;
                    state_d     = ST_LOAD_WAIT;
                end
                ST_LOAD_WAIT: begin
                    if (MEMCH_SCHEDULER_Load_Done) begin
                        load_req_d = 1'b0;
                        mask_d     = mask_q | bank_onehot(bank_q);
                        ch_en_s    = 1'b1;
                        // group closes on the third bank or on the layer's last channel
                        if ((bank_q == LAST_BANK) || ch_last_s) begin
                            state_d = ST_COMPUTE;
                        end else begin
                            bank_d  = bank_q + 2'd1;
                            state_d = ST_LOAD_REQ;
                        end
                    end else begin
                        state_d = ST_LOAD_WAIT;
                    end
                end
                ST_COMPUTE: begin
                    comp_start_d = 1'b1;
                    state_d      = ST_COMP_WAIT;
                end
                ST_COMP_WAIT: begin
                    if (MEMCH_SCHEDULER_Comp_Done) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_COMP_WAIT;
                    end
                end
                ST_DRAIN: begin
                    if (!MEMCH_SCHEDULER_In_Output_Routine) begin
                        state_d = ST_CLEAR;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_CLEAR: begin
                    bank_clr_d = mask_q;
                    mask_d     = MASK_NONE;
                    bank_d     = 2'd0;
                    if (ch_term_s) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_LOAD_REQ;
                    end
                end
                ST_FINISH: begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d    = ST_IDLE;
                    load_req_d = 1'b0;
                    mask_d     = MASK_NONE;
                    bank_d     = 2'd0;
                end
            endcase
        end

        busy_d = (state_d != ST_IDLE);
    end

    // state, bookkeeping and output registers
    always_ff @(posedge MEMCH_SCHEDULER_Clk) begin
        if (MEMCH_SCHEDULER_Reset) begin
            state_q      <= ST_IDLE;
            num_ch_q     <= '0;
            bank_q       <= 2'd0;
            mask_q       <= MASK_NONE;
            busy_q       <= 1'b0;
            load_req_q   <= 1'b0;
            load_ch_q    <= '0;
            load_bank_q  <= 2'd0;
            comp_start_q <= 1'b0;
            bank_clr_q   <= MASK_NONE;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            num_ch_q     <= num_ch_d;
            bank_q       <= bank_d;
            mask_q       <= mask_d;
            busy_q       <= busy_d;
            load_req_q   <= load_req_d;
            load_ch_q    <= load_ch_d;
            load_bank_q  <= load_bank_d;
            comp_start_q <= comp_start_d;
            bank_clr_q   <= bank_clr_d;
            done_q       <= done_d;
        end
    end

    assign MEMCH_SCHEDULER_Busy       = busy_q;
    assign MEMCH_SCHEDULER_Load_Req   = load_req_q;
    assign MEMCH_SCHEDULER_Load_Ch    = load_ch_q;
    assign MEMCH_SCHEDULER_Load_Bank  = load_bank_q;
    assign MEMCH_SCHEDULER_Comp_Start = comp_start_q;
    assign MEMCH_SCHEDULER_Comp_Mask  = mask_q;
    assign MEMCH_SCHEDULER_Bank_Clr   = bank_clr_q;
    assign MEMCH_SCHEDULER_Done       = done_q;

endmodule
